// File: rtl/prog_loader.sv
// prog_loader: streams 16-bit halfwords from a host, packs them high-half-first
// into 32-bit instruction words and writes them into the core's instruction
// memory. Holds the core in reset while loading.
//
// Ports:
//   clk, sys_rst_n         clock, synchronous active-low reset
//   start, len             load request and word count (1..DEPTH), sampled in IDLE
//   s_valid, s_data        host halfword stream
//   s_ready                loader accepts a halfword this cycle
//   mem_we/addr/wdata      instruction memory write port
//   cpu_rst                active-high core reset
//   busy, done             session in progress / one-cycle completion pulse
//   err                    sticky flag for a rejected start
//   checksum               sum mod 2^16 of halfwords accepted this session
module prog_loader #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          sys_rst_n,
    input  logic          start,
    input  logic [AW:0]   len,
    input  logic          s_valid,
    input  logic [15:0]   s_data,
    output logic          s_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          cpu_rst,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [15:0]   checksum
);

    localparam int unsigned HW = 16;
    localparam int unsigned WW = 32;
    localparam int unsigned LW = AW + 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HI    = 3'd1,
        ST_LO    = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [HW-1:0] hi_q, hi_d;
    logic [WW-1:0] wdata_q, wdata_d;
    logic [HW-1:0] checksum_q, checksum_d;
    logic          err_q, err_d;
    logic          cpu_rst_q, cpu_rst_d;
    logic          s_ready_q, s_ready_d;
    logic          mem_we_q, mem_we_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic hs;
    logic len_ok;
    logic last_word;

    // s_ready_q mirrors HI/LO membership, so the handshake needs no state decode.
    assign hs        = s_valid && s_ready_q;
    assign len_ok    = (len != '0) && (len <= LW'(DEPTH));
    assign last_word = ({1'b0, addr_q} == (len_q - LW'(1)));

    // State register
    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start && len_ok) state_d = ST_HI;
            ST_HI:    if (hs) state_d = ST_LO;
            ST_LO:    if (hs) state_d = ST_WRITE;
            ST_WRITE: state_d = last_word ? ST_DONE : ST_HI;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next values; status outputs are registered from state_d
    always_comb begin
        len_d      = len_q;
        addr_d     = addr_q;
        hi_d       = hi_q;
        wdata_d    = wdata_q;
        checksum_d = checksum_q;
        err_d      = err_q;
        cpu_rst_d  = cpu_rst_q;
        s_ready_d  = (state_d == ST_HI) || (state_d == ST_LO);
        mem_we_d   = (state_d == ST_WRITE);
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len_ok) begin
                        len_d      = len;
                        addr_d     = '0;
                        checksum_d = '0;
                        err_d      = 1'b0;
                        cpu_rst_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_HI: begin
                if (hs) begin
                    hi_d       = s_data;
                    checksum_d = checksum_q + s_data;
                end
            end
            ST_LO: begin
                if (hs) begin
                    wdata_d    = {hi_q, s_data};
                    checksum_d = checksum_q + s_data;
                end
            end
            ST_WRITE: begin
                // Hold on the last word so the address never wraps at len=DEPTH.
                if (!last_word) addr_d = addr_q + AW'(1);
            end
            ST_DONE: begin
                cpu_rst_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            len_q      <= '0;
            addr_q     <= '0;
            hi_q       <= '0;
            wdata_q    <= '0;
            checksum_q <= '0;
            err_q      <= 1'b0;
            cpu_rst_q  <= 1'b1;
            s_ready_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            len_q      <= len_d;
            addr_q     <= addr_d;
            hi_q       <= hi_d;
            wdata_q    <= wdata_d;
            checksum_q <= checksum_d;
            err_q      <= err_d;
            cpu_rst_q  <= cpu_rst_d;
            s_ready_q  <= s_ready_d;
            mem_we_q   <= mem_we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_rst   = cpu_rst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign checksum  = checksum_q;

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: drives load sessions and checks the memory image,
// checksum, handshake and status timing against a program-level model.
module tb_prog_loader;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    logic          clk = 1'b0;
    logic          sys_rst_n;
    logic          start;
    logic [AW:0]   len;
    logic          s_valid;
    logic [15:0]   s_data;
    logic          s_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_rst;
    logic          busy;
    logic          done;
    logic          err;
    logic [15:0]   checksum;

    int total = 0;
    int bad   = 0;

    // Observed memory image and activity log
    logic [31:0] mem_m [DEPTH];
    int          wr_cnt [DEPTH];
    int          wr_total;
    int          busy_cyc;
    int          done_cyc;
    int          viol = 0;
    logic        prev_we = 1'b0;
    logic [15:0] prog_q [$];
    logic [15:0] acc_q [$];

    prog_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .len       (len),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .checksum  (checksum)
    );

    always #5 clk = ~clk;

    // Mid-cycle observer: a write is only legal in a non-handshake, busy,
    // non-done cycle, and two writes are never adjacent.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            mem_m[mem_addr] = mem_wdata;
            wr_cnt[mem_addr]++;
            wr_total++;
            if (s_ready || !busy || done || prev_we) viol++;
        end
        prev_we = (mem_we === 1'b1);
        if (s_valid === 1'b1 && s_ready === 1'b1) acc_q.push_back(s_data);
        if (busy === 1'b1) busy_cyc++;
        if (done === 1'b1) done_cyc++;
    end

    // Reference model: plain arithmetic over the program
    function automatic logic [15:0] model_sum();
        int unsigned s = 0;
        foreach (prog_q[i]) s += prog_q[i];
        return 16'(s);
    endfunction

    function automatic logic [31:0] model_word(input int a);
        return {prog_q[2*a], prog_q[2*a+1]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        for (int i = 0; i < DEPTH; i++) begin
            wr_cnt[i] = 0;
            mem_m[i]  = '0;
        end
        wr_total = 0;
        busy_cyc = 0;
        done_cyc = 0;
        acc_q.delete();
    endtask

    task automatic do_start(input int l);
        start = 1'b1;
        len   = (AW+1)'(l);
        tick();
        start = 1'b0;
    endtask

    // Feed prog_q; optionally random s_valid and a stray start at index pulse_at
    task automatic send_prog(input bit rnd, input int pulse_at, output bit ok);
        int  i = 0;
        int  g = 0;
        bit  hs;
        while (i < prog_q.size() && g < 2000) begin
            s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data  = s_valid ? prog_q[i] : 16'($urandom);
            start   = (i == pulse_at);
            if (i == pulse_at) len = (AW+1)'(1);
            hs = s_valid && s_ready;
            tick();
            if (hs) i++;
            g++;
        end
        s_valid = 1'b0;
        start   = 1'b0;
        ok = (i == prog_q.size());
    endtask

    task automatic wait_done(output bit ok);
        int g = 0;
        while (done !== 1'b1 && g < 100) begin
            tick();
            g++;
        end
        ok = (done === 1'b1);
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        start     = 1'b1;
        len       = (AW+1)'(2);
        s_valid   = 1'b1;
        s_data    = 16'($urandom);
        tick();
        tick();
        total++;
        if ({cpu_rst, s_ready, mem_we, busy, done, err} !== 6'b100000) begin
            bad++;
            $display("FAIL reset_flags: got %b want 100000", {cpu_rst, s_ready, mem_we, busy, done, err});
        end
        total++;
        if ({checksum, mem_wdata, mem_addr} !== '0) begin
            bad++;
            $display("FAIL reset_data: got cs=%h wd=%h a=%h want 0", checksum, mem_wdata, mem_addr);
        end
        start     = 1'b0;
        s_valid   = 1'b0;
        sys_rst_n = 1'b1;
        tick();
        tick();
        total++;
        if ({busy, cpu_rst, s_ready} !== 3'b010) begin
            bad++;
            $display("FAIL reset_idle: got busy,cpu_rst,s_ready=%b want 010", {busy, cpu_rst, s_ready});
        end
    endtask

    task automatic test_basic();
        bit ok1, ok2;
        prog_q = '{16'h0840, 16'h0005, 16'h1080, 16'h0003};
        clear_log();
        do_start(2);
        total++;
        if ({busy, cpu_rst, s_ready} !== 3'b111) begin
            bad++;
            $display("FAIL basic_start: got busy,cpu_rst,s_ready=%b want 111", {busy, cpu_rst, s_ready});
        end
        send_prog(1'b0, -1, ok1);
        wait_done(ok2);
        total++;
        if (!(ok1 && ok2)) begin
            bad++;
            $display("FAIL basic_timeout: got sent=%0d done=%0d want 1 1", ok1, ok2);
        end
        total++;
        if (checksum !== model_sum() || cpu_rst !== 1'b1) begin
            bad++;
            $display("FAIL basic_checksum: got %h rst=%b want %h rst=1", checksum, cpu_rst, model_sum());
        end
        tick();
        total++;
        if ({done, cpu_rst, busy} !== 3'b000) begin
            bad++;
            $display("FAIL basic_release: got done,cpu_rst,busy=%b want 000", {done, cpu_rst, busy});
        end
        total++;
        if (done_cyc != 1 || busy_cyc != 7) begin
            bad++;
            $display("FAIL basic_cycles: got done=%0d busy=%0d want 1 7", done_cyc, busy_cyc);
        end
        for (int a = 0; a < 2; a++) begin
            total++;
            if (wr_cnt[a] != 1 || mem_m[a] !== model_word(a)) begin
                bad++;
                $display("FAIL basic_word%0d: got %h x%0d want %h x1", a, mem_m[a], wr_cnt[a], model_word(a));
            end
        end
        total++;
        if (wr_total != 2) begin
            bad++;
            $display("FAIL basic_wr_total: got %0d want 2", wr_total);
        end
    endtask

    task automatic test_bad_len();
        logic rst_before;
        clear_log();
        rst_before = cpu_rst;
        do_start(0);
        tick();
        total++;
        if ({err, busy, cpu_rst} !== {1'b1, 1'b0, rst_before}) begin
            bad++;
            $display("FAIL bad_len0: got err,busy,cpu_rst=%b want %b", {err, busy, cpu_rst}, {1'b1, 1'b0, rst_before});
        end
        do_start(17);
        tick();
        total++;
        if ({err, busy, cpu_rst} !== {1'b1, 1'b0, rst_before}) begin
            bad++;
            $display("FAIL bad_len17: got err,busy,cpu_rst=%b want %b", {err, busy, cpu_rst}, {1'b1, 1'b0, rst_before});
        end
        total++;
        if (wr_total != 0) begin
            bad++;
            $display("FAIL bad_len_writes: got %0d want 0", wr_total);
        end
    endtask

    task automatic test_backpressure();
        bit ok1, ok2;
        prog_q = '{16'h0840, 16'h0005, 16'h1080, 16'h0003};
        clear_log();
        do_start(2);
        total++;
        if ({err, busy} !== 2'b01) begin
            bad++;
            $display("FAIL bp_err_clear: got err,busy=%b want 01", {err, busy});
        end
        send_prog(1'b1, -1, ok1);
        wait_done(ok2);
        total++;
        if (!(ok1 && ok2) || checksum !== 16'h18C8) begin
            bad++;
            $display("FAIL bp_checksum: got %h ok=%0d%0d want 18c8 ok=11", checksum, ok1, ok2);
        end
        tick();
        total++;
        if (acc_q != prog_q) begin
            bad++;
            $display("FAIL bp_accepted: got %0d halfwords want %0d in order", acc_q.size(), prog_q.size());
        end
        for (int a = 0; a < 2; a++) begin
            total++;
            if (wr_cnt[a] != 1 || mem_m[a] !== model_word(a)) begin
                bad++;
                $display("FAIL bp_word%0d: got %h x%0d want %h x1", a, mem_m[a], wr_cnt[a], model_word(a));
            end
        end
    endtask

    task automatic test_full_depth();
        bit ok1, ok2;
        prog_q.delete();
        for (int i = 0; i < 2 * DEPTH; i++) prog_q.push_back(16'hFFFF);
        clear_log();
        do_start(DEPTH);
        send_prog(1'b0, 9, ok1);
        wait_done(ok2);
        total++;
        if (!(ok1 && ok2) || checksum !== 16'hFFE0 || checksum !== model_sum()) begin
            bad++;
            $display("FAIL full_checksum: got %h ok=%0d%0d want ffe0", checksum, ok1, ok2);
        end
        tick();
        total++;
        if (busy_cyc != 3 * DEPTH + 1 || done_cyc != 1) begin
            bad++;
            $display("FAIL full_cycles: got busy=%0d done=%0d want %0d 1", busy_cyc, done_cyc, 3 * DEPTH + 1);
        end
        for (int a = 0; a < DEPTH; a++) begin
            total++;
            if (wr_cnt[a] != 1 || mem_m[a] !== 32'hFFFF_FFFF) begin
                bad++;
                $display("FAIL full_word%0d: got %h x%0d want ffffffff x1", a, mem_m[a], wr_cnt[a]);
            end
        end
    endtask

    task automatic test_random();
        bit ok1, ok2;
        int n;
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, DEPTH);
            prog_q.delete();
            for (int i = 0; i < 2 * n; i++) prog_q.push_back(16'($urandom));
            clear_log();
            do_start(n);
            send_prog(1'b1, -1, ok1);
            wait_done(ok2);
            total++;
            if (!(ok1 && ok2) || checksum !== model_sum()) begin
                bad++;
                $display("FAIL rand%0d_checksum: got %h want %h ok=%0d%0d", r, checksum, model_sum(), ok1, ok2);
            end
            tick();
            total++;
            if (busy_cyc < 3 * n + 1 || done_cyc != 1 || cpu_rst !== 1'b0) begin
                bad++;
                $display("FAIL rand%0d_status: got busy=%0d done=%0d rst=%b want >=%0d 1 0",
                         r, busy_cyc, done_cyc, cpu_rst, 3 * n + 1);
            end
            for (int a = 0; a < DEPTH; a++) begin
                total++;
                if (wr_cnt[a] != (a < n ? 1 : 0) || (a < n && mem_m[a] !== model_word(a))) begin
                    bad++;
                    $display("FAIL rand%0d_word%0d: got %h x%0d want %h x%0d",
                             r, a, mem_m[a], wr_cnt[a], (a < n) ? model_word(a) : 32'h0, (a < n) ? 1 : 0);
                end
            end
        end
    endtask

    task automatic test_reset_mid_load();
        bit ok1, ok2;
        prog_q = '{16'h1234, 16'h5678, 16'h9ABC};
        do_start(2);
        send_prog(1'b0, -1, ok1);
        clear_log();
        sys_rst_n = 1'b0;
        s_valid   = 1'b1;
        s_data    = 16'hDEAD;
        tick();
        total++;
        if ({cpu_rst, s_ready, mem_we, busy, done, err} !== 6'b100000 || checksum !== 16'h0 || mem_addr !== '0) begin
            bad++;
            $display("FAIL midrst_values: got flags=%b cs=%h a=%h want 100000 0 0",
                     {cpu_rst, s_ready, mem_we, busy, done, err}, checksum, mem_addr);
        end
        tick();
        s_valid   = 1'b0;
        sys_rst_n = 1'b1;
        tick();
        tick();
        total++;
        if (!ok1 || wr_total != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL midrst_quiet: got writes=%0d busy=%b sent=%0d want 0 0 1", wr_total, busy, ok1);
        end
        prog_q = '{16'hD800, 16'h0000};
        clear_log();
        do_start(1);
        send_prog(1'b0, -1, ok1);
        wait_done(ok2);
        tick();
        total++;
        if (!(ok1 && ok2) || wr_total != 1 || wr_cnt[0] != 1 || mem_m[0] !== 32'hD800_0000) begin
            bad++;
            $display("FAIL midrst_reload: got %h writes=%0d want d8000000 writes=1", mem_m[0], wr_total);
        end
    endtask

    initial begin
        sys_rst_n = 1'b0;
        start     = 1'b0;
        len       = '0;
        s_valid   = 1'b0;
        s_data    = '0;
        clear_log();
        test_reset();
        test_basic();
        test_bad_len();
        test_backpressure();
        test_full_depth();
        test_random();
        test_reset_mid_load();
        total++;
        if (viol != 0) begin
            bad++;
            $display("FAIL write_placement: got %0d stray writes want 0", viol);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Program loader for the single-cycle-decode processor core. It receives a program from an external host as a stream of 16-bit halfwords over a valid/ready port and assembles them into 32-bit instruction words, high half first. Each word is written through a write port into the core's 16-entry instruction memory. The loader holds the core in reset while loading and releases it once the last word is committed.

## Interface
Parameters:
- DEPTH, 16, instruction memory depth in words
- AW, 4, instruction memory address width (log2 DEPTH)

Ports:
- clk  in  1  system clock
- sys_rst_n  in  1  one clock; reset is synchronous and active-low
- start  in  1  request a load session; sampled only in IDLE
- len  in  AW+1  number of instruction words to load; legal range 1..DEPTH
- s_valid  in  1  host halfword valid
- s_data  in  16  host halfword
- s_ready  out  1  loader accepts a halfword this cycle
- mem_we  out  1  instruction memory write enable
- mem_addr  out  AW  instruction memory write address
- mem_wdata  out  32  instruction word, {first halfword, second halfword}
- cpu_rst  out  1  active-high reset to the core
- busy  out  1  load session in progress
- done  out  1  one-cycle pulse when the session completes
- err  out  1  sticky flag for a rejected start
- checksum  out  16  sum mod 2^16 of all halfwords accepted in the current session

## Operation
- FSM states and transitions:
  - IDLE -> HI: on an accepted start.
  - HI -> LO: on a handshake. The loader captures s_data into the high half.
  - LO -> WRITE: on a handshake. The loader captures s_data into the low half.
  - WRITE -> HI: when more words remain.
  - WRITE -> DONE: after the word at address len-1.
  - DONE -> IDLE: unconditionally.
- A handshake is s_valid && s_ready at a rising edge. s_ready=1 only in HI and LO. s_data is ignored when there is no handshake.
- Accepted start: start=1 in IDLE with 1 <= len <= DEPTH. On accept:
  - latch len;
  - clear the address counter and checksum;
  - clear err;
  - set cpu_rst=1.
- Rejected start: start=1 in IDLE with len=0 or len>DEPTH. The loader sets err=1, stays in IDLE, performs no writes, and leaves cpu_rst unchanged.
- start outside IDLE is ignored. It does not restart or abort the session.
- WRITE state:
  - mem_we=1 for exactly one cycle, with mem_addr equal to the current address and mem_wdata equal to the assembled word.
  - The address increments at the end of WRITE.
  - Addresses run 0..len-1 and never wrap within a session.
- checksum adds every accepted halfword, modulo 2^16. It holds its value after DONE until the next accepted start.
- cpu_rst:
  - 1 from reset until the first completed session.
  - Set on an accepted start.
  - Cleared on the DONE->IDLE transition, so the core leaves reset with the full program in memory.
- busy=1 in HI, LO, WRITE and DONE. done=1 only in DONE.
- sys_rst_n=0 at any time, including mid-session, returns the loader to IDLE with reset values on the next edge. Partially written memory contents are left as they are, and no further writes occur.
- Reset values: FSM=IDLE, s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst=1, busy=0, done=0, err=0, checksum=0.

## Timing
- All outputs are registered or decoded from FSM state only. There is no combinational path from s_valid or start to any output.
- Start accepted at edge T: busy=1, cpu_rst=1 and s_ready=1 from cycle T+1.
- Second-halfword handshake at edge E: mem_we=1 during cycle E+1, and the memory commits at edge E+2.
- With s_valid held at 1, each word takes 3 cycles (HI, LO, WRITE). A len=N session spans 3N+1 cycles from the first HI cycle to the end of DONE.
- The done pulse occurs in the cycle after the final WRITE. cpu_rst=0 and busy=0 from the following cycle.
- Host stalls (s_valid=0) extend HI or LO indefinitely with no side effects.

## Test plan
- Reset: hold sys_rst_n=0 for 2 cycles, with start=1 and s_valid=1 driven. Required: cpu_rst=1; s_ready=0, mem_we=0, busy=0, done=0, err=0 and checksum=0; no state change.
- Basic load: len=2, halfwords 0x0840, 0x0005, 0x1080, 0x0003 with s_valid=1 throughout. Required:
  - write 0x08400005 to address 0, then 0x10800003 to address 1;
  - done pulses for 1 cycle and checksum=0x18C8;
  - cpu_rst falls the cycle after done;
  - 7 cycles from the first HI cycle to the end of DONE.
- Backpressure: the same program with s_valid toggling randomly. Required: identical writes and checksum, no duplicate or dropped halfwords, and mem_we is never asserted outside WRITE.
- Bad length: start with len=0, then with len=17. Required: err=1 after each, no mem_we, busy=0, cpu_rst unchanged. A following legal start clears err.
- Full depth: len=16 with 32 halfwords of 0xFFFF. Required: addresses 0..15 written exactly once, each with 0xFFFFFFFF, and checksum=0xFFE0. A start pulsed mid-session is ignored.
- Reset mid-load: assert sys_rst_n=0 after 3 accepted halfwords. Required: reset values on the next edge and no further writes. A new start with len=1 and halfwords 0xD800, 0x0000 then writes 0xD8000000 to address 0.
